// File: rtl/pipelined_fixed_multiplier.sv
// Lane-parallel signed fixed-point multiplier with per-beat rounding/saturation.
// Valid/ready pipeline with full back-pressure and an overflow-beat counter.
module pipelined_fixed_multiplier #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BIT    = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   weights,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   pixel_data,
    input  logic                                            round_en,
    input  logic                                            sat_en,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   result,
    output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]              ovf,
    output logic [CNT_WIDTH-1:0]                            ovf_count,
    input  logic                                            ovf_clear
);
    localparam int LANES = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int VW    = LANES * DATA_WIDTH;
    localparam int FS    = (PIPE_STAGES == 1) ? 1 : 2;
    localparam int ND    = PIPE_STAGES - FS + 1;

    function automatic logic [LANES*PW-1:0] mult_lanes(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [LANES*PW-1:0]     p;
        logic signed [DATA_WIDTH-1:0] x, y;
        logic signed [PW-1:0]    m;
        p = '0;
        for (int j = 0; j < LANES; j++) begin
            x = a[j*DATA_WIDTH +: DATA_WIDTH];
            y = b[j*DATA_WIDTH +: DATA_WIDTH];
            m = PW'(x) * PW'(y);
            p[j*PW +: PW] = m;
        end
        return p;
    endfunction

    function automatic logic signed [PW-1:0] rescale(input logic signed [PW-1:0] p, input logic rnd);
        logic signed [PW-1:0] half;
        half = '0;
        half[FRAC_BIT-1] = rnd;
        return (p + half) >>> FRAC_BIT;
    endfunction

    // Returns {ovf, lane}; out of range means the bits above the lane's sign bit disagree.
    function automatic logic [DATA_WIDTH:0] saturate(input logic signed [PW-1:0] s, input logic sat);
        logic                  o;
        logic [DATA_WIDTH-1:0] r;
        o = !((&s[PW-1:DATA_WIDTH-1]) || !(|s[PW-1:DATA_WIDTH-1]));
        r = s[DATA_WIDTH-1:0];
        if (sat && o)
            r = {s[PW-1], {(DATA_WIDTH-1){~s[PW-1]}}};
        return {o, r};
    endfunction

    function automatic logic [LANES+VW-1:0] scale_lanes(input logic [LANES*PW-1:0] p,
                                                        input logic rnd, input logic sat);
        logic [VW-1:0]    r;
        logic [LANES-1:0] o;
        r = '0;
        o = '0;
        for (int j = 0; j < LANES; j++)
            {o[j], r[j*DATA_WIDTH +: DATA_WIDTH]} = saturate(rescale($signed(p[j*PW +: PW]), rnd), sat);
        return {o, r};
    endfunction

    logic [PIPE_STAGES:1] vld_q;
    logic [PIPE_STAGES:1] adv;
    logic [LANES+VW-1:0]  sc_d;
    logic                 sc_vld;

    always_comb begin : p_adv
        logic nxt;
        adv = '0;
        nxt = out_ready;
        for (int k = PIPE_STAGES; k >= 1; k--) begin
            nxt    = !vld_q[k] || nxt;
            adv[k] = nxt;
        end
    end

    assign in_ready = adv[1];
    assign sc_vld   = (PIPE_STAGES == 1) ? in_valid : vld_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            if (adv[1])
                vld_q[1] <= in_valid;
            for (int k = 2; k <= PIPE_STAGES; k++)
                if (adv[k])
                    vld_q[k] <= vld_q[k-1];
        end
    end

    generate
        if (PIPE_STAGES > 1) begin : g_mul
            logic [LANES*PW-1:0] prod_q;
            logic                rnd_q;
            logic                sat_q;
            // Stage 1: full-width products; mode bits travel with the beat.
            always_ff @(posedge clk) begin
                if (adv[1] && in_valid) begin
                    prod_q <= mult_lanes(weights, pixel_data);
                    rnd_q  <= round_en;
                    sat_q  <= sat_en;
                end
            end
            assign sc_d = scale_lanes(prod_q, rnd_q, sat_q);
        end else begin : g_direct
            assign sc_d = scale_lanes(mult_lanes(weights, pixel_data), round_en, sat_en);
        end
    endgenerate

    logic [VW-1:0]    res_q [ND];
    logic [LANES-1:0] ovf_q [ND];

    // Stage FS: rescaled lanes; later stages are plain delay registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ND; i++) begin
                res_q[i] <= '0;
                ovf_q[i] <= '0;
            end
        end else begin
            if (adv[FS] && sc_vld)
                {ovf_q[0], res_q[0]} <= sc_d;
            for (int i = 1; i < ND; i++)
                if (adv[FS+i] && vld_q[FS+i-1]) begin
                    res_q[i] <= res_q[i-1];
                    ovf_q[i] <= ovf_q[i-1];
                end
        end
    end

    assign out_valid = vld_q[PIPE_STAGES];
    assign result    = res_q[ND-1];
    assign ovf       = ovf_q[ND-1];

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ovf_clear)
            cnt_d = '0;
        else if (out_valid && out_ready && (|ovf) && !(&cnt_q))
            cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign ovf_count = cnt_q;

endmodule

// File: tb/tb_pipelined_fixed_multiplier.sv
// Bench for pipelined_fixed_multiplier: queue-based reference model checked every
// cycle, plus literal vectors for rounding, saturation, back-pressure, counter and reset.
module tb_pipelined_fixed_multiplier;
    localparam int DW = 16;
    localparam int FB = 8;
    localparam int KS = 2;
    localparam int LN = KS * KS;
    localparam int P  = 3;
    localparam int VW = LN * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic          round_en = 1'b0;
    logic          sat_en = 1'b0;
    logic          ovf_clear = 1'b0;
    logic [VW-1:0] weights = '0;
    logic [VW-1:0] pixel_data = '0;

    logic          in_ready, out_valid;
    logic [VW-1:0] result;
    logic [LN-1:0] ovf;
    logic [15:0]   ovf_count;

    logic          c2_in_ready, c2_out_valid;
    logic [VW-1:0] c2_result;
    logic [LN-1:0] c2_ovf;
    logic [1:0]    c2_ovf_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_fixed_multiplier #(.DATA_WIDTH(DW), .FRAC_BIT(FB), .KERNEL_SIZE(KS),
                                 .PIPE_STAGES(P), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .weights(weights), .pixel_data(pixel_data), .round_en(round_en), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf),
        .ovf_count(ovf_count), .ovf_clear(ovf_clear));

    pipelined_fixed_multiplier #(.DATA_WIDTH(DW), .FRAC_BIT(FB), .KERNEL_SIZE(KS),
                                 .PIPE_STAGES(2), .CNT_WIDTH(2)) u_c2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c2_in_ready),
        .weights(weights), .pixel_data(pixel_data), .round_en(round_en), .sat_en(sat_en),
        .out_valid(c2_out_valid), .out_ready(1'b1), .result(c2_result), .ovf(c2_ovf),
        .ovf_count(c2_ovf_count), .ovf_clear(ovf_clear));

    typedef struct packed {
        logic [VW-1:0] res;
        logic [LN-1:0] ovf;
    } beat_t;

    beat_t exp_q[$];
    int    model_cnt = 0;
    int    delivered = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Reference: exact integer product, optional +half LSB, floor divide by 2^FB, range test.
    function automatic beat_t model(input logic [VW-1:0] w, input logic [VW-1:0] p,
                                    input logic rnd, input logic sat);
        beat_t  b;
        longint prod, s;
        b = '0;
        for (int j = 0; j < LN; j++) begin
            prod = longint'($signed(w[j*DW +: DW])) * longint'($signed(p[j*DW +: DW]));
            if (rnd)
                prod = prod + (longint'(1) <<< (FB - 1));
            s = prod >>> FB;
            b.ovf[j] = (s > 32767) || (s < -32768);
            if (sat && b.ovf[j])
                b.res[j*DW +: DW] = (s > 0) ? 16'h7FFF : 16'h8000;
            else
                b.res[j*DW +: DW] = s[DW-1:0];
        end
        return b;
    endfunction

    function automatic logic [VW-1:0] rep(input logic [15:0] x);
        return {LN{x}};
    endfunction

    always @(negedge clk or posedge reset) begin : monitor
        beat_t b;
        if (reset) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            check("in_ready", in_ready, (exp_q.size() < P) || out_ready);
            check("ovf_count", ovf_count, model_cnt);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got result %0h, expected no beat", result);
                end else begin
                    check("result", result, exp_q[0].res);
                    check("ovf", ovf, exp_q[0].ovf);
                end
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                b = exp_q.pop_front();
                delivered++;
                if ((|b.ovf) && model_cnt < 65535)
                    model_cnt++;
            end
            if (ovf_clear)
                model_cnt = 0;
            if (in_valid && in_ready)
                exp_q.push_back(model(weights, pixel_data, round_en, sat_en));
        end
    end

    task automatic lit(input string nm, input logic [VW-1:0] wv, input logic [VW-1:0] pv,
                       input logic rnd, input logic sat,
                       input logic [VW-1:0] er, input logic [LN-1:0] eo);
        int n, n2, n3;
        out_ready = 1'b1;
        weights = wv; pixel_data = pv; round_en = rnd; sat_en = sat; in_valid = 1'b1;
        n = 0; n2 = -1; n3 = -1;
        while ((n2 < 0 || n3 < 0) && n < 12) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) in_valid = 1'b0;
            if (n2 < 0 && c2_out_valid) begin
                n2 = n;
                check({nm, "_c2_res"}, c2_result, er);
                check({nm, "_c2_ovf"}, c2_ovf, eo);
            end
            if (n3 < 0 && out_valid) begin
                n3 = n;
                check({nm, "_res"}, result, er);
                check({nm, "_ovf"}, ovf, eo);
            end
        end
        check({nm, "_lat"}, n3, P);
        check({nm, "_lat_c2"}, n2, 2);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [VW-1:0] wv, input logic [VW-1:0] pv,
                        input logic rnd, input logic sat);
        logic ok;
        int   t;
        weights = wv; pixel_data = pv; round_en = rnd; sat_en = sat; in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
            t++;
        end while (!ok && t < 50);
        check("send_accept", ok, 1'b1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t, stale;
        logic [VW-1:0] w, p;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, '0);
        check("rst_ovf", ovf, '0);
        check("rst_ovf_count", ovf_count, 0);
        check("rst_c2_out_valid", c2_out_valid, 1'b0);
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_c2_in_ready", c2_in_ready, 1'b1);

        lit("basic",     rep(16'h0200), rep(16'h0180), 1'b0, 1'b0, rep(16'h0300), 4'h0);
        lit("trunc_pos", rep(16'h0001), rep(16'h0080), 1'b0, 1'b0, rep(16'h0000), 4'h0);
        lit("round_pos", rep(16'h0001), rep(16'h0080), 1'b1, 1'b0, rep(16'h0001), 4'h0);
        lit("trunc_neg", rep(16'hFFFF), rep(16'h0080), 1'b0, 1'b0, rep(16'hFFFF), 4'h0);
        lit("round_neg", rep(16'hFFFF), rep(16'h0080), 1'b1, 1'b0, rep(16'h0000), 4'h0);
        lit("sat_max",   rep(16'h7FFF), rep(16'h7FFF), 1'b0, 1'b1, rep(16'h7FFF), 4'hF);
        lit("wrap_max",  rep(16'h7FFF), rep(16'h7FFF), 1'b0, 1'b0, rep(16'hFF00), 4'hF);
        lit("sat_min",   rep(16'h8000), rep(16'h7FFF), 1'b0, 1'b1, rep(16'h8000), 4'hF);
        lit("mixed", {16'h0100, 16'h8000, 16'h0200, 16'h7FFF},
                     {16'hFF00, 16'h7FFF, 16'h0180, 16'h7FFF}, 1'b0, 1'b1,
                     {16'hFF00, 16'h8000, 16'h0300, 16'h7FFF}, 4'b0101);

        // Back-pressure: ten distinct beats, output stalled for five cycles mid-stream.
        delivered = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    for (int j = 0; j < LN; j++) begin
                        w[j*DW +: DW] = 16'((i + 1) * 256 + j * 3);
                        p[j*DW +: DW] = 16'(256 + i * 16 + j);
                    end
                    send(w, p, 1'(i % 2), 1'b0);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_low", in_ready, 1'b0);
                check("bp_out_valid_held", out_valid, 1'b1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_delivered", delivered, 10);

        // Overflow counter.
        ovf_clear = 1'b1;
        @(posedge clk); #1;
        ovf_clear = 1'b0;
        check("c2_cnt_cleared", c2_ovf_count, 0);
        for (int i = 0; i < 4; i++)
            send(rep(16'h7FFF), rep(16'h7FFF), 1'b0, 1'(i % 2));
        for (int i = 0; i < 2; i++)
            send(rep(16'h0200), rep(16'h0180), 1'b0, 1'b0);
        in_valid = 1'b0;
        drain();
        check("cnt_four", ovf_count, 4);
        send(rep(16'h8000), rep(16'h7FFF), 1'b0, 1'b1);
        in_valid = 1'b0;
        drain();
        check("cnt_five", ovf_count, 5);
        check("c2_cnt_saturated", c2_ovf_count, 3);

        send(rep(16'h7FFF), rep(16'h7FFF), 1'b0, 1'b1);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("clr_wait", out_valid, 1'b1);
        ovf_clear = 1'b1;
        @(posedge clk); #1;
        ovf_clear = 1'b0;
        check("clr_on_delivery", ovf_count, 0);

        // Reset with beats in flight.
        send(rep(16'h7FFF), rep(16'h7FFF), 1'b0, 1'b1);
        in_valid = 1'b0;
        drain();
        check("pre_reset_cnt", ovf_count, 1);
        send(rep(16'h7FFF), rep(16'h7FFF), 1'b0, 1'b1);
        send(rep(16'h0200), rep(16'h0180), 1'b0, 1'b0);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("mid_reset_wait", out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("mid_reset_out_valid", out_valid, 1'b0);
        check("mid_reset_result", result, '0);
        check("mid_reset_ovf", ovf, '0);
        check("mid_reset_cnt", ovf_count, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("post_reset_in_ready", in_ready, 1'b1);
        stale = 0;
        for (int i = 0; i < 2 * P; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check("post_reset_no_stale", stale, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_fixed_multiplier.md
Name: pipelined_fixed_multiplier

Overview:
Parametrised, pipelined lane-parallel signed fixed-point multiplier for the convolver datapath. It multiplies LANES pixel/weight pairs per beat and rescales each product to DATA_WIDTH by FRAC_BIT. Rounding and saturation are selectable per beat, with per-lane overflow flags. It sits between the window buffer and the adder tree and uses a valid/ready handshake with full back-pressure.

Parameters:
DATA_WIDTH, 16, signed operand and result width per lane
FRAC_BIT, 8, fractional bits of the Q format; legal range 1..DATA_WIDTH-1
KERNEL_SIZE, 5, kernel edge; LANES = KERNEL_SIZE**2
PIPE_STAGES, 2, register stages from input acceptance to output; legal range 1..4
CNT_WIDTH, 16, width of the overflow-beat counter

Ports:
clk  in  1  clock; all logic is on the rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
weights  in  LANES*DATA_WIDTH  signed weights; lane j = [j*DATA_WIDTH +: DATA_WIDTH]
pixel_data  in  LANES*DATA_WIDTH  signed pixels, same packing as weights
round_en  in  1  1 = round half toward +inf; 0 = truncate (floor); sampled with the beat
sat_en  in  1  1 = clamp to signed range; 0 = wrap; sampled with the beat
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts the beat
result  out  LANES*DATA_WIDTH  signed scaled products, same packing as inputs
ovf  out  LANES  per-lane flag: the rescaled value was outside the DATA_WIDTH signed range
ovf_count  out  CNT_WIDTH  count of delivered beats with any ovf bit set; saturates at all-ones
ovf_clear  in  1  synchronous clear of ovf_count

Behaviour:
- Reset is asynchronous. On reset assertion, all stage valid bits, out_valid, result, ovf and ovf_count go to 0 immediately. in_ready is 1 in the first cycle after reset deasserts.
- A beat is accepted on a cycle where in_valid && in_ready. A beat is delivered on a cycle where out_valid && out_ready.
- Each stage holds one beat. A stage advances when it is empty or the stage after it advances. in_ready = stage-1 empty OR stage 1 advances, so it is combinational from out_ready through the chain. Occupancy is at most PIPE_STAGES beats.
- Latency with no stall: a beat accepted at edge N produces out_valid and its result after edge N+PIPE_STAGES. Throughput is 1 beat per cycle when out_ready is held at 1.
- While out_valid=1 and out_ready=0, result, ovf and out_valid hold stable. No beat is dropped or duplicated, and beat order is preserved.
- Per-lane arithmetic:
  - p = a*b as a full 2*DATA_WIDTH signed product.
  - If round_en, add 2^(FRAC_BIT-1) to p.
  - s = p >>> FRAC_BIT (arithmetic shift).
  - ovf[j] = s > 2^(DATA_WIDTH-1)-1 or s < -2^(DATA_WIDTH-1).
  - If sat_en and ovf[j], result lane is the clamped bound (0x7FFF / 0x8000 at width 16).
  - Otherwise, result lane is s[DATA_WIDTH-1:0] (wrap).
- The multiply is registered in stage 1. Round, shift and clamp complete by the final stage. Extra stages are delay registers.
- round_en and sat_en travel with their beat. Changing them mid-stream does not affect beats already accepted.
- ovf_count increments by 1 on each delivered beat with |ovf, and saturates at 2^CNT_WIDTH-1.
  - ovf_clear has priority: a clear in the same cycle as a counted delivery gives ovf_count = 0.
  - ovf_count does not change on stalled cycles.
- If reset asserts mid-stream, all in-flight beats are discarded and no partial beat is emitted after reset.

Test Plan:
- Basic, DATA_WIDTH=16, FRAC_BIT=8, round_en=0, sat_en=0, all lanes a=0x0200, b=0x0180 -> after exactly PIPE_STAGES cycles, out_valid=1, every result lane =0x0300, ovf=0.
- Rounding: a=0x0001, b=0x0080 -> round_en=0 gives 0x0000; round_en=1 gives 0x0001. a=0xFFFF, b=0x0080 -> round_en=0 gives 0xFFFF; round_en=1 gives 0x0000.
- Saturation and wrap: a=b=0x7FFF -> sat_en=1 gives 0x7FFF; sat_en=0 gives 0xFF00. Both set ovf[j]=1. a=0x8000, b=0x7FFF -> sat_en=1 gives 0x8000 with ovf=1. Mixed lanes show flags only on the offending lanes.
- Back-pressure, PIPE_STAGES=3: stream 10 distinct beats with in_valid held at 1, and drop out_ready for 5 cycles mid-stream -> in_ready falls once 3 beats are held, output holds stable, all 10 results arrive in order with no loss or duplication.
- Counter: deliver 4 beats with overflow and 2 without -> ovf_count=4. ovf_clear asserted on a counted delivery -> ovf_count=0. With CNT_WIDTH=2, 5 overflow beats -> ovf_count=3.
- Reset mid-stream: assert reset while 2 beats are in flight -> out_valid, result and ovf_count are 0 immediately. After release, in_ready=1, and no stale beat appears over the next 2*PIPE_STAGES cycles.
